// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: operand selects, ALU ops, opcodes, immediate
// formats and the decode / ID-EX payload structs.
package riscv_pkg;
    localparam logic [1:0] SEL_REG  = 2'd0;
    localparam logic [1:0] SEL_IMM  = 2'd1;
    localparam logic [1:0] SEL_PC   = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OP_LUI      = 7'h37;
    localparam logic [6:0] OP_AUIPC    = 7'h17;
    localparam logic [6:0] OP_JAL      = 7'h6f;
    localparam logic [6:0] OP_JALR     = 7'h67;
    localparam logic [6:0] OP_BRANCH   = 7'h63;
    localparam logic [6:0] OP_LOAD     = 7'h03;
    localparam logic [6:0] OP_STORE    = 7'h23;
    localparam logic [6:0] OP_IMM      = 7'h13;
    localparam logic [6:0] OP_OP       = 7'h33;
    localparam logic [6:0] OP_MISC_MEM = 7'h0f;
    localparam logic [6:0] OP_SYSTEM   = 7'h73;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef struct packed {
        logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
        logic is_mem, we_mem, is_misc_mem, is_system;
    } flags_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] sel_a, sel_b;
        logic [2:0] imm_type;
        logic       uses_rs1, uses_rs2, writes_rd, illegal;
        flags_t     fl;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, dat_a, dat_b, store_dat, imm;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic [11:0] csr_addr;
        flags_t      fl;
        logic        illegal;
    } idex_t;

    // alt selects SUB / SRA; callers only raise it where the encoding allows.
    function automatic logic [3:0] alu_op_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/decoder.sv
// RV32I decoder: operand selects, ALU op, immediate format, register use and
// illegal detection (unknown opcode or register index beyond NUM_REGS).
module decoder
    import riscv_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       op_ok;
    logic       reg_bad;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];

    always_comb begin
        dec_o          = '0;
        dec_o.alu_op   = ALU_ADD;
        dec_o.sel_a    = SEL_ZERO;
        dec_o.sel_b    = SEL_ZERO;
        dec_o.imm_type = IMM_I;
        op_ok          = 1'b1;
        case (opcode)
            OP_LUI:      begin dec_o.sel_b = SEL_IMM; dec_o.imm_type = IMM_U; dec_o.writes_rd = 1'b1; dec_o.fl.is_lui = 1'b1; end
            OP_AUIPC:    begin dec_o.sel_a = SEL_PC; dec_o.sel_b = SEL_IMM; dec_o.imm_type = IMM_U; dec_o.writes_rd = 1'b1; dec_o.fl.is_auipc = 1'b1; end
            OP_JAL:      begin dec_o.sel_a = SEL_PC; dec_o.sel_b = SEL_IMM; dec_o.imm_type = IMM_J; dec_o.writes_rd = 1'b1; dec_o.fl.is_jal = 1'b1; end
            OP_JALR:     begin dec_o.sel_a = SEL_REG; dec_o.sel_b = SEL_IMM; dec_o.uses_rs1 = 1'b1; dec_o.writes_rd = 1'b1; dec_o.fl.is_jalr = 1'b1; end
            OP_BRANCH:   begin dec_o.sel_a = SEL_REG; dec_o.sel_b = SEL_REG; dec_o.alu_op = ALU_SUB; dec_o.imm_type = IMM_B;
                               dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1; dec_o.fl.is_branch = 1'b1; end
            OP_LOAD:     begin dec_o.sel_a = SEL_REG; dec_o.sel_b = SEL_IMM; dec_o.uses_rs1 = 1'b1; dec_o.writes_rd = 1'b1; dec_o.fl.is_mem = 1'b1; end
            OP_STORE:    begin dec_o.sel_a = SEL_REG; dec_o.sel_b = SEL_IMM; dec_o.imm_type = IMM_S; dec_o.uses_rs1 = 1'b1;
                               dec_o.uses_rs2 = 1'b1; dec_o.fl.is_mem = 1'b1; dec_o.fl.we_mem = 1'b1; end
            OP_IMM:      begin dec_o.sel_a = SEL_REG; dec_o.sel_b = SEL_IMM; dec_o.uses_rs1 = 1'b1; dec_o.writes_rd = 1'b1;
                               dec_o.alu_op = alu_op_f3(f3, (f3 == F3_SR) && instr_i[30]); end
            OP_OP:       begin dec_o.sel_a = SEL_REG; dec_o.sel_b = SEL_REG; dec_o.uses_rs1 = 1'b1; dec_o.uses_rs2 = 1'b1;
                               dec_o.writes_rd = 1'b1; dec_o.alu_op = alu_op_f3(f3, instr_i[30]); end
            OP_MISC_MEM: dec_o.fl.is_misc_mem = 1'b1;
            // CSR register forms read rs1; the immediate forms reuse the field as uimm.
            OP_SYSTEM:   begin dec_o.sel_a = SEL_REG; dec_o.uses_rs1 = ~f3[2] & (f3 != 3'd0);
                               dec_o.writes_rd = (f3 != 3'd0); dec_o.fl.is_system = 1'b1; end
            default:     op_ok = 1'b0;
        endcase
        reg_bad = (dec_o.writes_rd && ({1'b0, instr_i[11:7]} >= NREG))
               || (dec_o.uses_rs1 && ({1'b0, instr_i[19:15]} >= NREG))
               || (dec_o.uses_rs2 && ({1'b0, instr_i[24:20]} >= NREG));
        dec_o.illegal = !op_ok || reg_bad;
        if (dec_o.illegal) begin
            dec_o.fl        = '0;
            dec_o.writes_rd = 1'b0;
        end
    end
endmodule

// File: rtl/id_fwd_mux.sv
// Priority forward selector: lowest-index matching source wins, x0 reads zero.
module id_fwd_mux #(
    parameter int NUM_FWD = 2
) (
    input  logic [4:0]            rs_i,
    input  logic [31:0]           rf_dat_i,
    input  logic [NUM_FWD-1:0]    fwd_valid_i,
    input  logic [5*NUM_FWD-1:0]  fwd_rd_i,
    input  logic [32*NUM_FWD-1:0] fwd_dat_i,
    output logic [31:0]           dat_o
);
    always_comb begin
        dat_o = rf_dat_i;
        // Walk oldest to youngest so the youngest match overwrites.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid_i[i] && fwd_rd_i[5*i +: 5] == rs_i) dat_o = fwd_dat_i[32*i +: 32];
        end
        if (rs_i == 5'd0) dat_o = '0;
    end
endmodule

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for the I/S/B/U/J formats.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [2:0]  imm_type_i,
    output logic [31:0] imm_o
);
    always_comb begin
        case (imm_type_i)
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'h000};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
        endcase
    end
endmodule

// File: rtl/reg_file.sv
// Two-read one-write register file, x0 hardwired to zero.
// ID_RF_BYPASS_EN: a same-cycle write to the register being read is returned.
module reg_file #(
    parameter int NUM_REGS = 32
) (
    input  logic             clk_i,
    input  logic [1:0][4:0]  ra_i,
    output logic [1:0][31:0] rd_o,
    input  logic [4:0]       wa_i,
    input  logic [31:0]      wd_i,
    input  logic             we_i
);
    localparam int         AW   = $clog2(NUM_REGS);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    logic [31:0] mem_q [NUM_REGS];
    logic        wr_ok;

    assign wr_ok = we_i && (wa_i != 5'd0) && ({1'b0, wa_i} < NREG);

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wa_i[AW-1:0]] <= wd_i;
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_o[p] = '0;
            if (ra_i[p] != 5'd0 && {1'b0, ra_i[p]} < NREG) rd_o[p] = mem_q[ra_i[p][AW-1:0]];
`ifdef ID_RF_BYPASS_EN
            if (wr_ok && wa_i == ra_i[p]) rd_o[p] = wd_i;
`endif
        end
    end
endmodule

// File: rtl/stage_id_pipe.sv
// Decode stage with registered ID/EX boundary, forwarding, load-use bubble and
// valid/ready handshake. Optional macro ID_RF_BYPASS_EN enables RF write bypass.
module stage_id_pipe
    import riscv_pkg::*;
#(
    parameter int NUM_FWD  = 2,
    parameter int NUM_REGS = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [31:0]           instruction_i,
    input  logic [31:0]           pc_i,
    output logic                  stall_o,
    input  logic                  flush_i,
    input  logic                  ex_ready_i,
    input  logic                  ex_is_load_i,
    input  logic [4:0]            ex_rd_i,
    input  logic [4:0]            rd_i,
    input  logic [31:0]           rf_wd_i,
    input  logic                  rf_we_i,
    input  logic [NUM_FWD-1:0]    fwd_valid_i,
    input  logic [5*NUM_FWD-1:0]  fwd_rd_i,
    input  logic [32*NUM_FWD-1:0] fwd_dat_i,
    output logic                  valid_o,
    output logic [31:0]           pc_o,
    output logic [2:0]            funct3_o,
    output logic [4:0]            rd_o,
    output logic [3:0]            alu_op_o,
    output logic [11:0]           csr_addr_o,
    output logic [31:0]           dat_a_o,
    output logic [31:0]           dat_b_o,
    output logic [31:0]           store_dat_o,
    output logic [31:0]           imm_o,
    output logic                  is_lui_o,
    output logic                  is_auipc_o,
    output logic                  is_jal_o,
    output logic                  is_jalr_o,
    output logic                  is_branch_o,
    output logic                  is_mem_o,
    output logic                  we_mem_o,
    output logic                  is_misc_mem_o,
    output logic                  is_system_o,
    output logic                  e_illegal_inst_o
);
    dec_t             dec;
    logic [4:0]       rs1, rs2;
    logic [31:0]      imm, rs1_dat, rs2_dat;
    logic [1:0][31:0] rf_dat;
    logic             hold, hz;
    idex_t            idex_d, idex_q;

    assign rs1 = instruction_i[19:15];
    assign rs2 = instruction_i[24:20];

    decoder #(.NUM_REGS(NUM_REGS)) u_dec (.instr_i(instruction_i), .dec_o(dec));
    imm_gen u_imm (.instr_i(instruction_i), .imm_type_i(dec.imm_type), .imm_o(imm));
    reg_file #(.NUM_REGS(NUM_REGS)) u_rf (
        .clk_i(clk_i), .ra_i({rs2, rs1}), .rd_o(rf_dat),
        .wa_i(rd_i), .wd_i(rf_wd_i), .we_i(rf_we_i)
    );
    id_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd_rs1 (
        .rs_i(rs1), .rf_dat_i(rf_dat[0]), .fwd_valid_i(fwd_valid_i),
        .fwd_rd_i(fwd_rd_i), .fwd_dat_i(fwd_dat_i), .dat_o(rs1_dat)
    );
    id_fwd_mux #(.NUM_FWD(NUM_FWD)) u_fwd_rs2 (
        .rs_i(rs2), .rf_dat_i(rf_dat[1]), .fwd_valid_i(fwd_valid_i),
        .fwd_rd_i(fwd_rd_i), .fwd_dat_i(fwd_dat_i), .dat_o(rs2_dat)
    );

    function automatic logic [31:0] op_sel(input logic [1:0] sel, input logic [31:0] r,
                                           input logic [31:0] i, input logic [31:0] pc);
        case (sel)
            SEL_REG: return r;
            SEL_IMM: return i;
            SEL_PC:  return pc;
            default: return '0;
        endcase
    endfunction

    // A load still in EX cannot be forwarded yet; next cycle it arrives on fwd_*.
    assign hold    = idex_q.valid & ~ex_ready_i;
    assign hz      = valid_i & idex_q.valid & ex_is_load_i & (ex_rd_i != 5'd0)
                   & ((dec.uses_rs1 & (rs1 == ex_rd_i)) | (dec.uses_rs2 & (rs2 == ex_rd_i)));
    assign stall_o = hz | hold;

    always_comb begin
        idex_d = idex_q;
        if (flush_i) begin
            idex_d.valid = 1'b0;
        end else if (!hold) begin
            if (hz) begin
                idex_d = '0;
            end else if (valid_i) begin
                idex_d.valid     = 1'b1;
                idex_d.pc        = pc_i;
                idex_d.funct3    = instruction_i[14:12];
                idex_d.rd        = dec.writes_rd ? instruction_i[11:7] : 5'd0;
                idex_d.alu_op    = dec.alu_op;
                idex_d.csr_addr  = instruction_i[31:20];
                idex_d.dat_a     = op_sel(dec.sel_a, rs1_dat, imm, pc_i);
                idex_d.dat_b     = op_sel(dec.sel_b, rs2_dat, imm, pc_i);
                idex_d.store_dat = rs2_dat;
                idex_d.imm       = imm;
                idex_d.fl        = dec.fl;
                idex_d.illegal   = dec.illegal;
            end else begin
                idex_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign valid_o          = idex_q.valid;
    assign pc_o             = idex_q.pc;
    assign funct3_o         = idex_q.funct3;
    assign rd_o             = idex_q.rd;
    assign alu_op_o         = idex_q.alu_op;
    assign csr_addr_o       = idex_q.csr_addr;
    assign dat_a_o          = idex_q.dat_a;
    assign dat_b_o          = idex_q.dat_b;
    assign store_dat_o      = idex_q.store_dat;
    assign imm_o            = idex_q.imm;
    assign is_lui_o         = idex_q.fl.is_lui;
    assign is_auipc_o       = idex_q.fl.is_auipc;
    assign is_jal_o         = idex_q.fl.is_jal;
    assign is_jalr_o        = idex_q.fl.is_jalr;
    assign is_branch_o      = idex_q.fl.is_branch;
    assign is_mem_o         = idex_q.fl.is_mem;
    assign we_mem_o         = idex_q.fl.we_mem;
    assign is_misc_mem_o    = idex_q.fl.is_misc_mem;
    assign is_system_o      = idex_q.fl.is_system;
    assign e_illegal_inst_o = idex_q.illegal;
endmodule

// File: tb/tb_stage_id_pipe.sv
// Scoreboard bench for stage_id_pipe: expectations queued at issue, checked
// when EX takes the ID/EX register; an RV32E instance covers register range.
module tb_stage_id_pipe;
    logic        clk = 1'b0;
    logic        rst, valid_i, flush_i, ex_ready_i, ex_is_load_i, rf_we_i;
    logic [31:0] instruction_i, pc_i, rf_wd_i;
    logic [4:0]  ex_rd_i, rd_i;
    logic [1:0]  fwd_valid_i;
    logic [9:0]  fwd_rd_i;
    logic [63:0] fwd_dat_i;

    logic        stall_o, valid_o, e_illegal_inst_o;
    logic [31:0] pc_o, dat_a_o, dat_b_o, store_dat_o, imm_o;
    logic [2:0]  funct3_o;
    logic [4:0]  rd_o;
    logic [3:0]  alu_op_o;
    logic [11:0] csr_addr_o;
    logic        is_lui_o, is_auipc_o, is_jal_o, is_jalr_o, is_branch_o;
    logic        is_mem_o, we_mem_o, is_misc_mem_o, is_system_o;

    logic        e_stall, e_valid, e_ill;
    logic [31:0] e_pc, e_a, e_b, e_st, e_imm;
    logic [2:0]  e_f3;
    logic [4:0]  e_rd;
    logic [3:0]  e_alu;
    logic [11:0] e_csr;
    logic [8:0]  e_fl;

    logic [8:0]  fl;
    assign fl = {is_lui_o, is_auipc_o, is_jal_o, is_jalr_o, is_branch_o,
                 is_mem_o, we_mem_o, is_misc_mem_o, is_system_o};

    always #5 clk = ~clk;

    stage_id_pipe #(.NUM_FWD(2), .NUM_REGS(32)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .instruction_i(instruction_i), .pc_i(pc_i),
        .stall_o(stall_o), .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ex_is_load_i(ex_is_load_i),
        .ex_rd_i(ex_rd_i), .rd_i(rd_i), .rf_wd_i(rf_wd_i), .rf_we_i(rf_we_i),
        .fwd_valid_i(fwd_valid_i), .fwd_rd_i(fwd_rd_i), .fwd_dat_i(fwd_dat_i),
        .valid_o(valid_o), .pc_o(pc_o), .funct3_o(funct3_o), .rd_o(rd_o), .alu_op_o(alu_op_o),
        .csr_addr_o(csr_addr_o), .dat_a_o(dat_a_o), .dat_b_o(dat_b_o), .store_dat_o(store_dat_o),
        .imm_o(imm_o), .is_lui_o(is_lui_o), .is_auipc_o(is_auipc_o), .is_jal_o(is_jal_o),
        .is_jalr_o(is_jalr_o), .is_branch_o(is_branch_o), .is_mem_o(is_mem_o), .we_mem_o(we_mem_o),
        .is_misc_mem_o(is_misc_mem_o), .is_system_o(is_system_o), .e_illegal_inst_o(e_illegal_inst_o)
    );

    stage_id_pipe #(.NUM_FWD(2), .NUM_REGS(16)) dut_e (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .instruction_i(instruction_i), .pc_i(pc_i),
        .stall_o(e_stall), .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ex_is_load_i(ex_is_load_i),
        .ex_rd_i(ex_rd_i), .rd_i(rd_i), .rf_wd_i(rf_wd_i), .rf_we_i(rf_we_i),
        .fwd_valid_i(fwd_valid_i), .fwd_rd_i(fwd_rd_i), .fwd_dat_i(fwd_dat_i),
        .valid_o(e_valid), .pc_o(e_pc), .funct3_o(e_f3), .rd_o(e_rd), .alu_op_o(e_alu),
        .csr_addr_o(e_csr), .dat_a_o(e_a), .dat_b_o(e_b), .store_dat_o(e_st),
        .imm_o(e_imm), .is_lui_o(e_fl[8]), .is_auipc_o(e_fl[7]), .is_jal_o(e_fl[6]),
        .is_jalr_o(e_fl[5]), .is_branch_o(e_fl[4]), .is_mem_o(e_fl[3]), .we_mem_o(e_fl[2]),
        .is_misc_mem_o(e_fl[1]), .is_system_o(e_fl[0]), .e_illegal_inst_o(e_ill)
    );

    typedef struct {
        logic [31:0] pc, a, b;
        logic [4:0]  rd;
        logic [8:0]  fl;
        logic        ill, ops;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] ins, input logic [31:0] pc);
        valid_i       = 1'b1;
        instruction_i = ins;
        pc_i          = pc;
    endtask

    task automatic expect_op(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic [8:0] f, input logic ill, input logic ops);
        exp_t e;
        e.pc = pc; e.a = a; e.b = b; e.rd = rd; e.fl = f; e.ill = ill; e.ops = ops;
        sb.push_back(e);
    endtask

    // EX consumes the ID/EX register whenever it is valid and EX is ready.
    always @(negedge clk) begin
        if (!rst && valid_o && ex_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pc", pc_o, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_pc", pc_o, e.pc);
                chk("out_rd", {27'd0, rd_o}, {27'd0, e.rd});
                chk("out_illegal", {31'd0, e_illegal_inst_o}, {31'd0, e.ill});
                chk("out_flags", {23'd0, fl}, {23'd0, e.fl});
                if (e.ops) begin
                    chk("out_dat_a", dat_a_o, e.a);
                    chk("out_dat_b", dat_b_o, e.b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [31:0] x4_exp;

    initial begin
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1; ex_is_load_i = 1'b0;
        rf_we_i = 1'b0; instruction_i = '0; pc_i = '0; rf_wd_i = '0; ex_rd_i = '0; rd_i = '0;
        fwd_valid_i = '0; fwd_rd_i = '0; fwd_dat_i = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_dat_a", dat_a_o, 32'd0);
        chk("rst_rd", {27'd0, rd_o}, 32'd0);
        tick();
        rst = 1'b0;
        rf_we_i = 1'b1; rd_i = 5'd2; rf_wd_i = 32'd7;
        tick();
        rd_i = 5'd4; rf_wd_i = 32'h44;
        tick();
        rf_we_i = 1'b0;
        @(negedge clk);
        chk("stall_after_rst", {31'd0, stall_o}, 32'd0);

        // ADDI x1, x0, 5
        put(32'h0050_0093, 32'h100);
        expect_op(32'h100, 32'd0, 32'd5, 5'd1, 9'h000, 1'b0, 1'b1);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        chk("latency_valid", {31'd0, valid_o}, 32'd1);
        tick();

        // ADD x3, x1, x2 with both sources offering x1: index 0 wins
        fwd_valid_i = 2'b11; fwd_rd_i = {5'd1, 5'd1}; fwd_dat_i = {32'hBB, 32'hAA};
        put(32'h0020_81B3, 32'h104);
        expect_op(32'h104, 32'hAA, 32'd7, 5'd3, 9'h000, 1'b0, 1'b1);
        tick();
        valid_i = 1'b0; fwd_valid_i = '0;
        tick();

        // LW x5 then dependent ADD x6, x5, x0
        put(32'h0000_2283, 32'h108);
        expect_op(32'h108, 32'd0, 32'd0, 5'd5, 9'h008, 1'b0, 1'b1);
        tick();
        put(32'h0002_8333, 32'h10C);
        ex_is_load_i = 1'b1; ex_rd_i = 5'd5;
        @(negedge clk);
        chk("hz_stall", {31'd0, stall_o}, 32'd1);
        tick();
        ex_is_load_i = 1'b0; ex_rd_i = 5'd0;
        fwd_valid_i = 2'b01; fwd_rd_i = {5'd0, 5'd5}; fwd_dat_i = {32'd0, 32'h1234};
        expect_op(32'h10C, 32'h1234, 32'd0, 5'd6, 9'h000, 1'b0, 1'b1);
        @(negedge clk);
        chk("hz_bubble", {31'd0, valid_o}, 32'd0);
        chk("hz_stall_clear", {31'd0, stall_o}, 32'd0);
        tick();
        valid_i = 1'b0; fwd_valid_i = '0;
        tick();

        // EX back-pressure for three cycles, then flush of the held entry
        put(32'h0090_0393, 32'h110);
        expect_op(32'h110, 32'd0, 32'd9, 5'd7, 9'h000, 1'b0, 1'b1);
        tick();
        put(32'h00A0_0413, 32'h114);
        ex_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_stall", {31'd0, stall_o}, 32'd1);
            chk("hold_valid", {31'd0, valid_o}, 32'd1);
            chk("hold_pc", pc_o, sb[0].pc);
            chk("hold_dat_b", dat_b_o, sb[0].b);
            tick();
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; valid_i = 1'b0; ex_ready_i = 1'b1;
        void'(sb.pop_front());
        @(negedge clk);
        chk("flush_valid", {31'd0, valid_o}, 32'd0);
        tick();

        // Same-cycle writeback of x4 while ADD x9, x4, x0 reads it
`ifdef ID_RF_BYPASS_EN
        x4_exp = 32'hDEAD;
`else
        x4_exp = 32'h44;
`endif
        rf_we_i = 1'b1; rd_i = 5'd4; rf_wd_i = 32'hDEAD;
        put(32'h0002_04B3, 32'h118);
        expect_op(32'h118, x4_exp, 32'd0, 5'd9, 9'h000, 1'b0, 1'b1);
        tick();
        rf_we_i = 1'b0;
        put(32'h0002_04B3, 32'h11C);
        expect_op(32'h11C, 32'hDEAD, 32'd0, 5'd9, 9'h000, 1'b0, 1'b1);
        tick();
        valid_i = 1'b0;
        tick();

        // Unknown opcode
        put(32'h0000_007F, 32'h120);
        expect_op(32'h120, 32'd0, 32'd0, 5'd0, 9'h000, 1'b1, 1'b0);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        chk("ill_valid", {31'd0, valid_o}, 32'd1);
        tick();

        // ADD x17, x1, x2: legal with 32 registers, illegal on the RV32E instance
        put(32'h0020_88B3, 32'h124);
        expect_op(32'h124, 32'd0, 32'd0, 5'd17, 9'h000, 1'b0, 1'b0);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        chk("rv32e_illegal", {31'd0, e_ill}, 32'd1);
        chk("rv32e_valid", {31'd0, e_valid}, 32'd1);
        chk("rv32e_rd", {27'd0, e_rd}, 32'd0);
        tick();

        // Flush drops an otherwise acceptable instruction
        put(32'h0050_0093, 32'h128);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        chk("flush_drop", {31'd0, valid_o}, 32'd0);
        repeat (2) tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stage_id_pipe.md
# stage_id_pipe

Parametrised decode stage with a registered ID/EX boundary. It decodes the instruction and reads the register file. It resolves operands through an N-source forwarding network, detects load-use hazards, and presents a valid/ready handshake to IF and EX. It replaces the combinational decode stage between `stage_if` and `stage_ex`, and adds stall, flush and bubble insertion.

## Interface
Parameters:
- `NUM_FWD`, 2: number of forwarding sources. Index 0 is the youngest and has the highest priority.
- `NUM_REGS`, 32: architectural registers, 32 or 16 (RV32E). Register indices at or above `NUM_REGS` raise illegal.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `valid_i` in 1: IF presents an instruction.
- `instruction_i` in 32: instruction word.
- `pc_i` in 32: PC of the instruction.
- `stall_o` out 1: ID cannot accept; IF must hold.
- `flush_i` in 1: kill ID contents (taken branch or trap).
- `ex_ready_i` in 1: EX can accept the ID/EX register.
- `ex_is_load_i` in 1: a load is currently in EX.
- `ex_rd_i` in 5: destination of the instruction in EX.
- `rd_i` in 5, `rf_wd_i` in 32, `rf_we_i` in 1: writeback port.
- `fwd_valid_i` in NUM_FWD: per-source forward valid.
- `fwd_rd_i` in 5*NUM_FWD: per-source destination register.
- `fwd_dat_i` in 32*NUM_FWD: per-source data.
- `valid_o` out 1: ID/EX register holds a live instruction.
- `pc_o` out 32, `funct3_o` out 3, `rd_o` out 5, `alu_op_o` out 4, `csr_addr_o` out 12.
- `dat_a_o` out 32, `dat_b_o` out 32: ALU operands.
- `store_dat_o` out 32: forwarded rs2 value.
- `imm_o` out 32: immediate.
- `is_lui_o`, `is_auipc_o`, `is_jal_o`, `is_jalr_o`, `is_branch_o`, `is_mem_o`, `we_mem_o`, `is_misc_mem_o`, `is_system_o`, `e_illegal_inst_o`, each out 1.

## Operation
- Operand select per ALU input, encoded in 2 bits: REG, IMM, PC or ZERO.
- Forwarding for the REG source:
  - rs==0 always reads 0.
  - Otherwise the lowest index i with `fwd_valid_i[i]` and `fwd_rd_i[i]==rs` wins.
  - If no source matches, the register-file value is used.
- `store_dat_o` always carries the forwarded rs2 value, independent of `sel_dat_b`.
- Load-use hazard is `hz`, asserted when all of the following hold:
  - `valid_i` and `valid_o` are both 1.
  - `ex_is_load_i` is 1 and `ex_rd_i` is nonzero.
  - `ex_rd_i` equals an rs that the decoded instruction actually uses.
- `stall_o = hz | (valid_o & ~ex_ready_i)`.
- Illegal instruction:
  - `e_illegal_inst_o=1` and `valid_o=1`.
  - All `is_*` flags and `we_mem_o` are forced to 0.
  - `rd_o` is forced to 0.

## Timing
- Reset: every output register is 0, including `valid_o`. `stall_o` is 0 one cycle after reset deasserts.
- Latency: 1 cycle from accept (`valid_i & ~stall_o`) to `valid_o`.
- Per-edge update priority, highest first:
  1. `rst_i`: clear all.
  2. `flush_i`: `valid_o←0`. The instruction on `instruction_i` is dropped even if it was acceptable.
  3. `valid_o & ~ex_ready_i`: hold all outputs unchanged.
  4. `hz`: `valid_o←0` (bubble). Payload is don't-care but driven 0. IF holds.
  5. `valid_i`: load the new decode.
  6. Otherwise: `valid_o←0`.
- `flush_i` together with `ex_ready_i=0` still clears `valid_o`. EX must tolerate a valid drop.
- Writeback and read in the same cycle on the same register return `rf_wd_i` (see Configuration).
- `hz` resolves in one cycle. On the next edge the load has left EX and is covered by `fwd_*`.

## Configuration
- `ID_RF_BYPASS_EN`:
  - Defined: the read path returns `rf_wd_i` when `rf_we_i` is 1, `rd_i` is nonzero, and `rd_i` equals rs.
  - Undefined: the raw register-file value is returned. The writeback stage must then appear as a `fwd_*` source.

## Structure
- Shared package `riscv_pkg` holds:
  - SEL_REG/IMM/PC/ZERO.
  - ALU op codes.
  - Opcode and funct3 constants.
  - Immediate-type encodings.
- Reuse `decoder`, `reg_file` (parametrised by `NUM_REGS`) and `imm_gen`.
- One new sub-module, `id_fwd_mux`: the parametrised priority forward selector, instantiated twice (rs1 and rs2).
- The ID/EX register and hazard logic live in the top module.

## Test plan
- Reset then ADDI x1,x0,5 with `valid_i=1`, `ex_ready_i=1` -> next cycle `valid_o=1`, `dat_a_o=0`, `dat_b_o=5`, `rd_o=1`.
- ADD x3,x1,x2 with fwd0=(x1,0xAA) and fwd1=(x1,0xBB); x2 comes from the register file with value 7 -> `dat_a_o=0xAA`, `dat_b_o=7`.
- LW x5 in EX (`ex_is_load_i=1`, `ex_rd_i=5`), then ADD x6,x5,x0 in ID -> `stall_o=1` for one cycle and a bubble (`valid_o=0`). The next cycle, with fwd0=(x5,0x1234), gives `dat_a_o=0x1234`.
- `ex_ready_i=0` for 3 cycles while `valid_o=1` -> outputs are stable and `stall_o=1`. Then `flush_i=1` -> `valid_o=0` on the next edge.
- Same-cycle writeback x4=0xDEAD and read of x4 -> with `ID_RF_BYPASS_EN` `dat_a_o=0xDEAD`; without it the old value.
- Opcode 0x7F -> `e_illegal_inst_o=1`, `valid_o=1`, all `is_*` flags 0. With `NUM_REGS=16`, ADD x17,... -> illegal.
